// File: rtl/code_loader_pkg.sv
// Shared types and constants for the code RAM boot loader.
package code_loader_pkg;

  localparam int CODE_ADDR_W = 8;
  localparam int CODE_DATA_W = 16;
  localparam logic [8:0] COUNT_ZERO_WORDS = 9'd256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    COUNT  = 3'd2,
    HI     = 3'd3,
    LO     = 3'd4,
    WRITE  = 3'd5,
    CHK    = 3'd6,
    FINISH = 3'd7
  } state_t;

  // States in which the loader takes a byte off the serial front end.
  function automatic logic is_rx_state(input state_t s);
    return (s == ADDR) || (s == COUNT) || (s == HI) || (s == LO) || (s == CHK);
  endfunction

  function automatic logic [8:0] frame_words(input logic [7:0] c);
    return (c == 8'd0) ? COUNT_ZERO_WORDS : {1'b0, c};
  endfunction

endpackage

// File: rtl/code_loader_wdog.sv
// Inter-byte idle watchdog: counts enabled cycles since the last clear and
// flags the cycle on which the TIMEOUT_CYCLES-th idle cycle ends.
module code_loader_wdog #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_r;
  logic          armed_s;

  // A zero TIMEOUT_CYCLES leaves the counter parked and never fires.
  always_comb begin
    armed_s = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      armed_s = en && (cnt_r == LAST);
    end else begin
      armed_s = 1'b0;
    end
  end

  assign timeout = armed_s;

  // Idle cycle counter, saturating at the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (TIMEOUT_CYCLES != 0) && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/code_loader.sv
// Boot loader writing a framed byte stream into the code RAM while the CPU is
// held in reset. Optional trailing checksum byte: CODE_LOADER_CHECKSUM_EN.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [7:0]             RX_DATA,
  input  logic                   RX_VALID,
  output logic                   RX_READY,
  output logic                   WE,
  output logic [CODE_ADDR_W-1:0] WADDR,
  output logic [CODE_DATA_W-1:0] WDATA,
  output logic                   CPU_HOLD,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR
);

  state_t                 state_r;
  state_t                 state_s;
  logic [CODE_ADDR_W-1:0] addr_r;
  logic [7:0]             hi_r;
  logic [8:0]             rem_r;
  logic                   rx_ready_r;
  logic                   we_r;
  logic [CODE_ADDR_W-1:0] waddr_r;
  logic [CODE_DATA_W-1:0] wdata_r;
  logic                   hold_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   error_r;
  logic                   accept_s;
  logic                   start_s;
  logic                   timeout_s;
  logic                   abort_s;

  assign accept_s = RX_VALID && rx_ready_r;
  assign start_s  = (state_r == IDLE) && START;

  code_loader_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (CLK),
    .rst    (RESET),
    .clr    (accept_s || !rx_ready_r),
    .en     (rx_ready_r && !accept_s),
    .timeout(timeout_s)
  );

`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0] sum_r;
  logic [7:0] sum_next_s;
  logic       chk_ok_s;

  assign sum_next_s = sum_r + RX_DATA;
  assign chk_ok_s   = (sum_next_s == 8'h00);

  // Running mod-256 sum of every accepted byte of the frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sum_r <= 8'h00;
    end else if (start_s) begin
      sum_r <= 8'h00;
    end else if (accept_s) begin
      sum_r <= sum_next_s;
    end else begin
      sum_r <= sum_r;
    end
  end
`endif

  // Next-state logic; the watchdog overrides any waiting state.
  always_comb begin
    state_s = state_r;
    abort_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) state_s = ADDR;
        else       state_s = IDLE;
      end
      ADDR: begin
        if (accept_s) state_s = COUNT;
        else          state_s = ADDR;
      end
      COUNT: begin
        if (accept_s) state_s = HI;
        else          state_s = COUNT;
      end
      HI: begin
        if (accept_s) state_s = LO;
        else          state_s = HI;
      end
      LO: begin
        if (accept_s) state_s = WRITE;
        else          state_s = LO;
      end
      WRITE: begin
        if (rem_r == 9'd0) begin
`ifdef CODE_LOADER_CHECKSUM_EN
          state_s = CHK;
`else
          state_s = FINISH;
`endif
        end else begin
          state_s = HI;
        end
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_s && chk_ok_s) begin
          state_s = FINISH;
        end else if (accept_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = CHK;
        end
      end
`endif
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (timeout_s) begin
      state_s = IDLE;
      abort_s = 1'b1;
    end else begin
      abort_s = abort_s;
    end
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= IDLE;
      rx_ready_r <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      hold_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      rx_ready_r <= is_rx_state(state_s);
      we_r       <= (state_s == WRITE);
      busy_r     <= (state_s != IDLE) && (state_s != FINISH);
      hold_r     <= (state_s != IDLE) && (state_s != FINISH);
    end
  end

  // Sticky status flags, cleared when a new frame starts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else if (start_s) begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      done_r  <= done_r || (state_s == FINISH);
      error_r <= error_r || abort_s;
    end
  end

  // Frame datapath: address, remaining words, high byte, write port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_r  <= '0;
      rem_r   <= 9'd0;
      hi_r    <= 8'h00;
      waddr_r <= '0;
      wdata_r <= '0;
    end else if (accept_s) begin
      case (state_r)
        ADDR:  addr_r <= RX_DATA;
        COUNT: rem_r  <= frame_words(RX_DATA);
        HI:    hi_r   <= RX_DATA;
        LO: begin
          waddr_r <= addr_r;
          wdata_r <= {hi_r, RX_DATA};
          addr_r  <= addr_r + 1'b1;
          rem_r   <= rem_r - 9'd1;
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end else begin
      addr_r <= addr_r;
    end
  end

  assign RX_READY = rx_ready_r;
  assign WE       = we_r;
  assign WADDR    = waddr_r;
  assign WDATA    = wdata_r;
  assign CPU_HOLD = hold_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign ERROR    = error_r;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: directed spec vectors plus random frames
// checked against a frame-level model of the expected code RAM writes.
module tb_code_loader;

  localparam int TO = 20;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic        WE;
  logic [7:0]  WADDR;
  logic [15:0] WDATA;
  logic        CPU_HOLD;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  int tests = 0;
  int fails = 0;
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];

  code_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY), .WE(WE), .WADDR(WADDR),
    .WDATA(WDATA), .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WE === 1'b1) obs_q.push_back({WADDR, WDATA});
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected writes: word i of the frame lands at (addr + i) mod 256.
  task automatic model(input logic [7:0] f[$], output logic [23:0] w[$]);
    int n;
    w = {};
    n = (f[1] == 8'd0) ? 256 : int'(f[1]);
    for (int i = 0; i < n; i++) w.push_back({f[0] + 8'(i), f[2 + 2*i], f[3 + 2*i]});
  endtask

  // Called and returns at a negedge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    RX_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
    RX_DATA = b;
    RX_VALID = 1'b1;
    n = 0;
    while (RX_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("rx_ready_wait", 32'(n), 32'd0);
    @(posedge CLK);
    #1 RX_VALID = 1'b0;
    RX_DATA = $urandom_range(0, 255);
    @(negedge CLK);
  endtask

  task automatic expect_idle_regs(input string tag);
    chk({tag, "_rdy"}, 32'(RX_READY), 32'd0);
    chk({tag, "_we"}, 32'(WE), 32'd0);
    chk({tag, "_waddr"}, 32'(WADDR), 32'd0);
    chk({tag, "_wdata"}, 32'(WDATA), 32'd0);
    chk({tag, "_flags"}, {28'd0, CPU_HOLD, BUSY, DONE, ERROR}, 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$], input int fgap,
                           input int rgap, input bit poke, input bit add_chk);
    logic [7:0] fb[$];
    logic [7:0] s;
    int nw;
    int n;
    fb = f;
    model(f, exp_q);
    nw = exp_q.size();
    s = 8'h00;
    foreach (f[i]) s = s + f[i];
    if (add_chk) fb.push_back(8'h00 - s);
    obs_q = {};
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk({tag, "_busy"}, {30'd0, BUSY, CPU_HOLD}, 32'd3);
    chk({tag, "_clr"}, {30'd0, DONE, ERROR}, 32'd0);
    foreach (fb[i]) begin
      START = poke && (i < fb.size() - 1);
      send_byte(fb[i], fgap + int'($urandom_range(0, rgap)));
      if (i >= 3 && i < 2 + 2*nw && (i % 2) == 1) begin
        chk({tag, "_we_lat"}, {30'd0, WE, RX_READY}, 32'd2);
        chk({tag, "_waddr"}, 32'(WADDR), 32'(exp_q[(i - 3) / 2][23:16]));
      end
    end
    START = 1'b0;
    n = 0;
    while (DONE !== 1'b1 && ERROR !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_end_wait"}, 32'(n < 10), 32'd1);
    chk({tag, "_finish"}, {28'd0, DONE, ERROR, BUSY, CPU_HOLD}, 32'h8);
    @(negedge CLK);
    chk({tag, "_sticky"}, {30'd0, DONE, BUSY}, 32'd2);
    chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < obs_q.size(); i++)
      chk({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0] f[$];
    bit ck;
`ifdef CODE_LOADER_CHECKSUM_EN
    ck = 1'b1;
`else
    ck = 1'b0;
`endif
    #3;
    expect_idle_regs("reset");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    f = '{8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame("basic", f, 0, 0, 1'b0, ck);
    chk("basic_w0", 32'(obs_q[0]), 32'h101234);
    chk("basic_w1", 32'(obs_q[1]), 32'h11ABCD);

    f = '{8'hFF, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
    run_frame("wrap", f, 0, 0, 1'b0, ck);
    chk("wrap_w1", 32'(obs_q[1]), 32'h000002);

    f = '{8'h40, 8'h00};
    for (int i = 0; i < 512; i++) f.push_back(8'($urandom_range(0, 255)));
    run_frame("cnt256", f, 0, 0, 1'b0, ck);
    chk("cnt256_last", 32'(obs_q[255][23:16]), 32'h3F);

    f = '{8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame("gap3", f, 2, 0, 1'b1, ck);

    for (int r = 0; r < 6; r++) begin
      f = {};
      f.push_back(8'($urandom_range(0, 255)));
      f.push_back(8'($urandom_range(1, 6)));
      for (int i = 0; i < 2 * int'(f[1]); i++) f.push_back(8'($urandom_range(0, 255)));
      run_frame("rand", f, 0, 4, 1'($urandom_range(0, 1)), ck);
    end

    // Watchdog: stall after the high byte.
    obs_q = {};
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    repeat (TO - 1) @(negedge CLK);
    chk("wdog_pre", {30'd0, ERROR, BUSY}, 32'd1);
    @(negedge CLK);
    chk("wdog_fire", {28'd0, ERROR, BUSY, CPU_HOLD, DONE}, 32'h8);
    chk("wdog_rdy", 32'(RX_READY), 32'd0);
    repeat (3) @(negedge CLK);
    chk("wdog_nowe", 32'(obs_q.size()), 32'd0);

    // Reset with a write in flight.
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    send_byte(8'h30, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("midrst_we", 32'(WE), 32'd1);
    #2 RESET = 1'b1;
    #1;
    expect_idle_regs("midrst");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    f = '{8'h50, 8'h01, 8'hBE, 8'hEF};
    run_frame("postrst", f, 0, 1, 1'b0, ck);

`ifdef CODE_LOADER_CHECKSUM_EN
    f = '{8'h10, 8'h01, 8'h12, 8'h34, 8'hA9};
    run_frame("chk_ok", f[0:3], 0, 0, 1'b0, 1'b1);
    obs_q = {};
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    foreach (f[i]) send_byte((i == 4) ? 8'hA8 : f[i], 0);
    repeat (2) @(negedge CLK);
    chk("chk_bad", {29'd0, ERROR, DONE, CPU_HOLD}, 32'h4);
    chk("chk_bad_wr", 32'(obs_q.size()), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
